// File: rtl/gups_pkg.sv
// Shared definitions for the GUPS memory controller: controller states,
// default geometry and the data-path width.
package gups_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int RD_LAT_DEF = 2;
    localparam int DATA_W     = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP,
        WAIT_WR,
        WR_ISSUE,
        WR_RESP,
        DRAIN
    } state_t;

endpackage

// File: rtl/gups_lat_cnt.sv
// Loadable 3-bit down-counter that times the SRAM read latency; zero is
// asserted while the counter is at 0 and the counter saturates there.
module gups_lat_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == 3'd0);

endmodule

// File: rtl/gups_mem_ctrl.sv
// Read-modify-write SRAM controller for the GUPS update generator: one read
// phase, one write phase, an update counter, and clean abort of partial updates.
module gups_mem_ctrl
    import gups_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [63:0]       address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       updates,
    output logic              busy
);

    state_t state;
    state_t next_state;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;
    logic   capture;
    logic   aborted;

    // Upper address bits alias onto the SRAM; they are intentionally dropped.
    generate
        if (ADDR_W < 64) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[63:ADDR_W];
        end
    endgenerate

    // Loaded as the read strobe is registered, so it hits zero exactly in the
    // cycle mem_rdata becomes valid.
    gups_lat_cnt u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (3'(RD_LAT)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign cnt_dec = (state == RD_ISSUE) || (state == RD_WAIT);

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !wr) begin
                    next_state = RD_ISSUE;
                    cnt_load   = 1'b1;
                end
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT: begin
                if (cnt_zero) begin
                    if (req && !aborted) begin
                        next_state = RD_RESP;
                        capture    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RD_RESP: next_state = req ? WAIT_WR : IDLE;
            WAIT_WR: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (wr) begin
                    next_state = WR_ISSUE;
                end
            end
            WR_ISSUE: next_state = WR_RESP;
            WR_RESP:  next_state = DRAIN;
            DRAIN: begin
                if (!req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes and status are decoded from next_state so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            updates   <= '0;
            aborted   <= 1'b0;
        end else begin
            state  <= next_state;
            ready  <= (next_state == RD_RESP) || (next_state == WR_RESP);
            mem_en <= (next_state == RD_ISSUE) || (next_state == WR_ISSUE);
            mem_we <= (next_state == WR_ISSUE);
            busy   <= (next_state != IDLE);
            if (cnt_load) begin
                mem_addr <= address[ADDR_W-1:0];
            end
            if (capture) begin
                rdata <= mem_rdata;
            end
            if ((state == WAIT_WR) && (next_state == WR_ISSUE)) begin
                mem_wdata <= wdata;
            end
            if (next_state == WR_RESP) begin
                updates <= updates + 32'd1;
            end
            if (state == IDLE) begin
                aborted <= 1'b0;
            end else if ((state == RD_WAIT) && !req) begin
                aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gups_mem_ctrl.sv
// Directed self-checking bench for gups_mem_ctrl with a latency-accurate
// SRAM model and a bench-side update generator with its own reference memory.
module tb_gups_mem_ctrl;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [63:0] address = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic        ready;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [31:0] updates;
    logic        busy;

    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [63:0] pre_data = '0;
    logic        mem_clear = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [63:0]       mem [0:65535];
    logic [63:0]       rd_pipe [0:RD_LAT-1];
    logic [RD_LAT-1:0] rd_vld = '0;
    logic [63:0]       model_mem [0:255];

    always #5 clk = ~clk;

    gups_mem_ctrl #(.ADDR_W(16), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wr        (wr),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .updates   (updates),
        .busy      (busy)
    );

    // SRAM model: read data is only valid exactly RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= mem[mem_addr];
        rd_vld[0]  <= (mem_en === 1'b1) && (mem_we === 1'b0);
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= rd_vld[i-1];
        end
    end

    assign mem_rdata = rd_vld[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [63:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++; if (ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", ready); else passes++;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("[TB] FAIL rst_strobe: got en=%b we=%b want 0/0", mem_en, mem_we); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (rdata !== 64'h0 || mem_wdata !== 64'h0) $display("[TB] FAIL rst_data: got rdata=%h wdata=%h want 0", rdata, mem_wdata); else passes++;
        checks++; if (mem_addr !== 16'h0 || updates !== 32'h0) $display("[TB] FAIL rst_addr_upd: got addr=%h upd=%0d want 0/0", mem_addr, updates); else passes++;
    endtask

    task automatic test_idle_ignore();
        req = 1'b1; wr = 1'b1; address = 64'd5;
        step(); step();
        checks++; if (mem_en !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL idle_ignore: got en=%b busy=%b want 0/0", mem_en, busy); else passes++;
        req = 1'b0; wr = 1'b0;
        step();
    endtask

    task automatic test_update();
        preload(16'd5, 64'h10);
        req = 1'b1; wr = 1'b0; address = 64'd5;
        step();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) $display("[TB] FAIL rd_strobe: got en=%b we=%b want 1/0", mem_en, mem_we); else passes++;
        checks++; if (mem_addr !== 16'd5 || busy !== 1'b1) $display("[TB] FAIL rd_addr: got addr=%h busy=%b want 5/1", mem_addr, busy); else passes++;
        step();
        checks++; if (mem_en !== 1'b0) $display("[TB] FAIL rd_strobe_len: got %b want 0", mem_en); else passes++;
        step();
        checks++; if (ready !== 1'b0) $display("[TB] FAIL rd_ready_early: got %b want 0", ready); else passes++;
        step();
        checks++; if (ready !== 1'b1) $display("[TB] FAIL rd_ready: got %b want 1", ready); else passes++;
        checks++; if (rdata !== 64'h10) $display("[TB] FAIL rd_data: got %h want 10", rdata); else passes++;
        step();
        checks++; if (ready !== 1'b0) $display("[TB] FAIL rd_ready_len: got %b want 0", ready); else passes++;
        wr = 1'b1; wdata = 64'h11;
        step();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) $display("[TB] FAIL wr_strobe: got en=%b we=%b want 1/1", mem_en, mem_we); else passes++;
        checks++; if (mem_wdata !== 64'h11) $display("[TB] FAIL wr_data: got %h want 11", mem_wdata); else passes++;
        step();
        checks++; if (ready !== 1'b1 || updates !== 32'd1) $display("[TB] FAIL wr_ready: got ready=%b upd=%0d want 1/1", ready, updates); else passes++;
        checks++; if (mem[5] !== 64'h11) $display("[TB] FAIL wr_mem: got %h want 11", mem[5]); else passes++;
        req = 1'b0; wr = 1'b0;
        step();
        checks++; if (ready !== 1'b0 || mem_en !== 1'b0) $display("[TB] FAIL drain_quiet: got ready=%b en=%b want 0/0", ready, mem_en); else passes++;
        step();
        checks++; if (busy !== 1'b0) $display("[TB] FAIL upd_idle: got busy=%b want 0", busy); else passes++;
    endtask

    task automatic test_abort_rd_wait();
        logic seen_rdy = 1'b0;
        logic seen_we = 1'b0;
        preload(16'd7, 64'h77);
        req = 1'b1; wr = 1'b0; address = 64'd7;
        step(); step();
        req = 1'b0;
        for (int i = 0; i < RD_LAT + 1; i++) begin
            step();
            if (ready === 1'b1) seen_rdy = 1'b1;
            if (mem_we === 1'b1) seen_we = 1'b1;
        end
        checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else passes++;
        checks++; if (seen_rdy !== 1'b0 || seen_we !== 1'b0) $display("[TB] FAIL abort_quiet: got ready=%b we=%b want 0/0", seen_rdy, seen_we); else passes++;
        checks++; if (rdata !== 64'h10 || updates !== 32'd1) $display("[TB] FAIL abort_state: got rdata=%h upd=%0d want 10/1", rdata, updates); else passes++;
    endtask

    task automatic test_abort_wait_wr();
        logic seen_we = 1'b0;
        preload(16'd9, 64'h99);
        req = 1'b1; wr = 1'b0; address = 64'd9;
        for (int i = 0; i < 16; i++) begin
            if (ready === 1'b1) break;
            step();
        end
        checks++; if (ready !== 1'b1 || rdata !== 64'h99) $display("[TB] FAIL ww_read: got ready=%b rdata=%h want 1/99", ready, rdata); else passes++;
        step();
        req = 1'b0; wr = 1'b1; wdata = 64'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_we === 1'b1) seen_we = 1'b1;
        end
        checks++; if (seen_we !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL ww_abort: got we=%b busy=%b want 0/0", seen_we, busy); else passes++;
        checks++; if (updates !== 32'd1 || mem[9] !== 64'h99) $display("[TB] FAIL ww_state: got upd=%0d mem=%h want 1/99", updates, mem[9]); else passes++;
        wr = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        preload(16'd3, 64'h30);
        req = 1'b1; wr = 1'b0; address = 64'd3;
        for (int i = 0; i < 16; i++) begin
            if (ready === 1'b1) break;
            step();
        end
        wr = 1'b1; wdata = 64'h31;
        for (int i = 0; i < 16; i++) begin
            if (mem_we === 1'b1) break;
            step();
        end
        checks++; if (mem_we !== 1'b1) $display("[TB] FAIL rmw_reach_wr: got we=%b want 1", mem_we); else passes++;
        reset = 1'b1;
        step();
        checks++; if (mem_en !== 1'b0 || ready !== 1'b0) $display("[TB] FAIL rmw_strobe: got en=%b ready=%b want 0/0", mem_en, ready); else passes++;
        checks++; if (updates !== 32'd0 || busy !== 1'b0) $display("[TB] FAIL rmw_state: got upd=%0d busy=%b want 0/0", updates, busy); else passes++;
        reset = 1'b0; req = 1'b0; wr = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || mem_en !== 1'b0) $display("[TB] FAIL rmw_idle: got busy=%b en=%b want 0/0", busy, mem_en); else passes++;
    endtask

    task automatic test_alias();
        logic bad_drain = 1'b0;
        preload(16'd3, 64'hAB);
        req = 1'b1; wr = 1'b0; address = 64'h1_0003;
        step();
        checks++; if (mem_addr !== 16'h0003) $display("[TB] FAIL alias_addr: got %h want 0003", mem_addr); else passes++;
        for (int i = 0; i < 16; i++) begin
            if (ready === 1'b1) break;
            step();
        end
        checks++; if (rdata !== 64'hAB) $display("[TB] FAIL alias_rdata: got %h want ab", rdata); else passes++;
        wr = 1'b1; wdata = 64'hAC;
        step();
        for (int i = 0; i < 16; i++) begin
            if (ready === 1'b1) break;
            step();
        end
        checks++; if (updates !== 32'd1 || mem[3] !== 64'hAC) $display("[TB] FAIL alias_write: got upd=%0d mem=%h want 1/ac", updates, mem[3]); else passes++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy !== 1'b1 || ready !== 1'b0 || mem_en !== 1'b0) bad_drain = 1'b1;
        end
        checks++; if (bad_drain !== 1'b0) $display("[TB] FAIL drain_hold: got misbehaviour=%b want 0", bad_drain); else passes++;
        req = 1'b0; wr = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0 || updates !== 32'd1) $display("[TB] FAIL drain_exit: got busy=%b upd=%0d want 0/1", busy, updates); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] x = 32'h1234;
        logic [7:0]  a;
        int          timeouts = 0;
        int          rd_err = 0;
        int          mem_err = 0;
        reset = 1'b1; mem_clear = 1'b1;
        step();
        reset = 1'b0; mem_clear = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        for (int n = 0; n < 1000; n++) begin
            x = x ^ (x << 13); x = x ^ (x >> 17); x = x ^ (x << 5);
            a = x[7:0];
            req = 1'b1; wr = 1'b0; address = {56'h0, a};
            step();
            for (int i = 0; i < 16; i++) begin
                if (ready === 1'b1) break;
                step();
            end
            if (ready !== 1'b1) begin timeouts++; break; end
            if (rdata !== model_mem[a]) rd_err++;
            wr = 1'b1; wdata = rdata + 64'd1;
            step();
            for (int i = 0; i < 16; i++) begin
                if (ready === 1'b1) break;
                step();
            end
            if (ready !== 1'b1) begin timeouts++; break; end
            model_mem[a] = model_mem[a] + 64'd1;
            req = 1'b0; wr = 1'b0;
            step();
            for (int i = 0; i < 16; i++) begin
                if (busy === 1'b0) break;
                step();
            end
            if (busy !== 1'b0) begin timeouts++; break; end
        end
        req = 1'b0; wr = 1'b0;
        step();
        for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) mem_err++;
        checks++; if (timeouts != 0) $display("[TB] FAIL gen_timeout: got %0d timeouts want 0", timeouts); else passes++;
        checks++; if (rd_err != 0) $display("[TB] FAIL gen_rdata: got %0d bad reads want 0", rd_err); else passes++;
        checks++; if (updates !== 32'd1000) $display("[TB] FAIL gen_updates: got %0d want 1000", updates); else passes++;
        checks++; if (mem_err != 0) $display("[TB] FAIL gen_mem: got %0d bad words want 0", mem_err); else passes++;
    endtask

    initial begin
        $display("[TB] gups_mem_ctrl bench start");
        test_reset();
        test_idle_ignore();
        test_update();
        test_abort_rd_wait();
        test_abort_wait_wr();
        test_reset_mid_write();
        test_alias();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
